// File: rtl/sprite_pkg.sv
// Shared definitions for the scanline sprite fetcher: SAT word layout,
// fetcher FSM encoding, line limits and the sprite chain entry.
package sprite_pkg;

    // Sprite height in lines (power of 2, at most 16) and pushes per line.
    localparam int unsigned SPR_H    = 16;
    localparam int unsigned MAX_LINE = 8;

    // SAT word 0 fields
    localparam int unsigned W0_POSY_LSB = 0;   // 9 bits
    localparam int unsigned W0_POSX_LSB = 9;   // 9 bits
    localparam int unsigned W0_SCLX_LSB = 18;  // 4 bits
    localparam int unsigned W0_SWPX_BIT = 22;
    localparam int unsigned W0_EN_BIT   = 23;

    // SAT word 1 fields
    localparam int unsigned W1_BCOL1_LSB = 0;   // 5 bits each
    localparam int unsigned W1_BCOL2_LSB = 5;
    localparam int unsigned W1_BCOL3_LSB = 10;
    localparam int unsigned W1_BCOL4_LSB = 15;
    localparam int unsigned W1_PBASE_LSB = 20;  // 12 bits

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StA0,
        StW0,
        StE0,
        StA1,
        StW1,
        StE1,
        StAp,
        StWp,
        StEp,
        StPush,
        StNext,
        StDone
    } fetch_state_e;

    // One slot of the sprite shift chain.
    typedef struct packed {
        logic [8:0]  pos_x;
        logic [3:0]  scl_x;
        logic        swp_x;
        logic [4:0]  bcol1;
        logic [4:0]  bcol2;
        logic [4:0]  bcol3;
        logic [4:0]  bcol4;
        logic [31:0] colors;
    } chain_ent_t;

endpackage

// File: rtl/sat_hit_eval.sv
// Decides whether a SAT entry (word 0) covers line i_ny and which sprite row it is.
module sat_hit_eval
    import sprite_pkg::*;
(
    input  logic [31:0] i_word0,
    input  logic [8:0]  i_ny,
    output logic        o_hit,
    output logic [3:0]  o_row
);

    logic [8:0] w_pos_y;
    logic [8:0] w_row9;
    logic       w_unused;

    // Row is taken modulo 512 so a sprite can straddle the top of the frame.
    always_comb begin
        w_pos_y = i_word0[W0_POSY_LSB +: 9];
        w_row9  = i_ny - w_pos_y;
        o_hit   = i_word0[W0_EN_BIT] && (32'(w_row9) < SPR_H);
        o_row   = w_row9[3:0];
    end

    assign w_unused = ^{i_word0[31:24], i_word0[22:9]};

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite evaluator: during hblank walks the SAT, picks up to
// MAX_LINE sprites for the next line and pushes them into the sprite chain.
module sprite_line_fetch
    import sprite_pkg::*;
#(
    parameter logic [15:0] SAT_BASE = 16'hF000,
    parameter int unsigned NUM_SPR  = 32,
    parameter int unsigned START_X  = 640,
    parameter int unsigned ACTIVE_H = 480,
    parameter int unsigned LAST_Y   = 524
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  CounterX,
    input  logic [8:0]  CounterY,
    input  logic [31:0] fromRAM,
    output logic [15:0] addr,
    output logic        clr,
    output logic        shift,
    output logic [8:0]  posX,
    output logic [3:0]  sclX,
    output logic        swpX,
    output logic [4:0]  bcol1,
    output logic [4:0]  bcol2,
    output logic [4:0]  bcol3,
    output logic [4:0]  bcol4,
    output logic [31:0] colors,
    output logic        busy,
    output logic        overflow
);

    fetch_state_e r_state, w_next;
    logic [5:0]   r_idx;
    logic [3:0]   r_hits;
    logic [8:0]   r_ny;
    logic [3:0]   r_row;
    logic [11:0]  r_pbase;
    logic [15:0]  r_addr;
    logic         r_ovf;
    chain_ent_t   r_ent;

    logic [8:0]   w_ny;
    logic         w_trig;
    logic         w_hit;
    logic [3:0]   w_row;
    logic         w_last;
    logic         w_full;

    sat_hit_eval u_hit (
        .i_word0 (fromRAM),
        .i_ny    (r_ny),
        .o_hit   (w_hit),
        .o_row   (w_row)
    );

    // Next line number and scan trigger; LAST_Y compared at full width so a
    // value outside the 9-bit CounterY range never aliases onto a real line.
    always_comb begin
        if (32'(CounterY) == LAST_Y) w_ny = 9'd0;
        else                         w_ny = CounterY + 9'd1;
        w_trig = (CounterX == 10'(START_X)) && (32'(w_ny) < ACTIVE_H);
        w_last = (32'(r_idx) == NUM_SPR - 1);
        w_full = (32'(r_hits) == MAX_LINE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= StIdle;
        else      r_state <= w_next;
    end

    // Next-state logic; once the line is full, hits are evaluated but not fetched.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (w_trig) w_next = StClr;
            StClr:   w_next = StA0;
            StA0:    w_next = StW0;
            StW0:    w_next = StE0;
            StE0:    w_next = (w_hit && !w_full) ? StA1 : StNext;
            StA1:    w_next = StW1;
            StW1:    w_next = StE1;
            StE1:    w_next = StAp;
            StAp:    w_next = StWp;
            StWp:    w_next = StEp;
            StEp:    w_next = StPush;
            StPush:  w_next = StNext;
            StNext:  w_next = w_last ? StDone : StA0;
            StDone:  w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    // Control outputs decoded from state
    always_comb begin
        clr   = (r_state == StClr);
        shift = (r_state == StPush);
        busy  = (r_state != StIdle);
    end

    // Datapath: RAM address, SAT index/hit counters and the slot being built.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx   <= '0;
            r_hits  <= '0;
            r_ny    <= '0;
            r_row   <= '0;
            r_pbase <= '0;
            r_addr  <= '0;
            r_ovf   <= 1'b0;
            r_ent   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_trig) begin
                        r_ny <= w_ny;
                        if (w_ny == 9'd0) r_ovf <= 1'b0;
                    end
                end
                StClr: begin
                    r_idx  <= '0;
                    r_hits <= '0;
                end
                StA0: r_addr <= SAT_BASE + {9'd0, r_idx, 1'b0};
                StE0: begin
                    r_ent.pos_x <= fromRAM[W0_POSX_LSB +: 9];
                    r_ent.scl_x <= fromRAM[W0_SCLX_LSB +: 4];
                    r_ent.swp_x <= fromRAM[W0_SWPX_BIT];
                    r_row       <= w_row;
                    if (w_hit && w_full) r_ovf <= 1'b1;
                end
                StA1: r_addr <= SAT_BASE + {9'd0, r_idx, 1'b1};
                StE1: begin
                    r_ent.bcol1 <= fromRAM[W1_BCOL1_LSB +: 5];
                    r_ent.bcol2 <= fromRAM[W1_BCOL2_LSB +: 5];
                    r_ent.bcol3 <= fromRAM[W1_BCOL3_LSB +: 5];
                    r_ent.bcol4 <= fromRAM[W1_BCOL4_LSB +: 5];
                    r_pbase     <= fromRAM[W1_PBASE_LSB +: 12];
                end
                StAp:   r_addr <= {r_pbase, r_row};
                StEp:   r_ent.colors <= fromRAM;
                StPush: r_hits <= r_hits + 4'd1;
                StNext: if (!w_last) r_idx <= r_idx + 6'd1;
                default: ;
            endcase
        end
    end

    assign addr     = r_addr;
    assign overflow = r_ovf;
    assign posX     = r_ent.pos_x;
    assign sclX     = r_ent.scl_x;
    assign swpX     = r_ent.swp_x;
    assign bcol1    = r_ent.bcol1;
    assign bcol2    = r_ent.bcol2;
    assign bcol3    = r_ent.bcol3;
    assign bcol4    = r_ent.bcol4;
    assign colors   = r_ent.colors;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: RAM model, chain monitor and a line-level
// reference model computed straight from the SAT contents.
module tb_sprite_line_fetch;

    localparam logic [15:0] SAT  = 16'hF000;
    localparam int unsigned NSPR = 32;
    localparam int unsigned STX  = 640;
    localparam int unsigned AH   = 480;
    localparam int unsigned LY   = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  CounterX;
    logic [8:0]  CounterY;
    logic [31:0] fromRAM;
    logic [15:0] addr;
    logic        clr, shift, swpX, busy, overflow;
    logic [8:0]  posX;
    logic [3:0]  sclX;
    logic [4:0]  bcol1, bcol2, bcol3, bcol4;
    logic [31:0] colors;

    sprite_line_fetch #(
        .SAT_BASE (SAT),
        .NUM_SPR  (NSPR),
        .START_X  (STX),
        .ACTIVE_H (AH),
        .LAST_Y   (LY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .CounterX (CounterX),
        .CounterY (CounterY),
        .fromRAM  (fromRAM),
        .addr     (addr),
        .clr      (clr),
        .shift    (shift),
        .posX     (posX),
        .sclX     (sclX),
        .swpX     (swpX),
        .bcol1    (bcol1),
        .bcol2    (bcol2),
        .bcol3    (bcol3),
        .bcol4    (bcol4),
        .colors   (colors),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // RAM: data for an address is presented one cycle later, sampled on the 2nd edge.
    logic [31:0] mem [0:65535];
    always @(posedge clk) fromRAM <= mem[addr];

    // Monitor: records clr pulses, pushed chain entries and the address trace.
    int          n_clr = 0;
    logic [65:0] got_q[$];
    logic [15:0] addr_q[$];
    always @(negedge clk) begin
        if (clr === 1'b1) n_clr++;
        if (shift === 1'b1)
            got_q.push_back({posX, sclX, swpX, bcol1, bcol2, bcol3, bcol4, colors});
        addr_q.push_back(addr);
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [65:0] exp_q[$];
    bit          exp_ovf = 1'b0;
    int          line_s0, line_a0;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: scan every SAT entry in index order, keep the first 8 hits.
    task automatic model_line(input logic [8:0] ny);
        int hits;
        hits = 0;
        exp_q.delete();
        if (ny == 9'd0) exp_ovf = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            logic [31:0] w0, w1;
            logic [8:0]  row;
            w0  = mem[SAT + 16'(2 * i)];
            w1  = mem[SAT + 16'(2 * i + 1)];
            row = ny - w0[8:0];
            if (w0[23] && row < 9'd16) begin
                if (hits < 8) begin
                    exp_q.push_back({w0[17:9], w0[21:18], w0[22], w1[4:0], w1[9:5],
                                     w1[14:10], w1[19:15], mem[{w1[31:20], row[3:0]}]});
                    hits++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    // Run one hblank for CounterY=y; optional second START_X pulse at cycle rep.
    task automatic run_line(input logic [8:0] y, input int rep);
        logic [8:0] ny;
        int c0, n, m;
        ny      = (32'(y) == LY) ? 9'd0 : y + 9'd1;
        c0      = n_clr;
        line_s0 = got_q.size();
        line_a0 = addr_q.size();
        if (32'(ny) < AH) model_line(ny);
        else exp_q.delete();
        CounterY = y;
        CounterX = 10'(STX);
        @(negedge clk);
        CounterX = 10'd0;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            CounterX = (n == rep) ? 10'(STX) : 10'd0;
            @(negedge clk);
            n++;
        end
        CounterX = 10'd0;
        chk("scan_done", 66'(busy), 66'd0);
        chk("clr_count", 66'(n_clr - c0), (32'(ny) < AH) ? 66'd1 : 66'd0);
        chk("shift_count", 66'(got_q.size() - line_s0), 66'(exp_q.size()));
        m = (got_q.size() - line_s0 < exp_q.size()) ? got_q.size() - line_s0 : exp_q.size();
        for (int k = 0; k < m; k++) chk($sformatf("entry%0d", k), got_q[line_s0 + k], exp_q[k]);
        chk("overflow", 66'(overflow), 66'(exp_ovf));
    endtask

    task automatic clear_sat();
        for (int i = 0; i < NSPR; i++) begin
            mem[SAT + 16'(2 * i)]     = $urandom & 32'hFF7F_FFFF;
            mem[SAT + 16'(2 * i + 1)] = $urandom;
        end
    endtask

    task automatic set_w0(input int i, input bit en, input logic [8:0] py, input logic [8:0] px,
                          input logic [3:0] scl, input bit swp);
        mem[SAT + 16'(2 * i)] = {8'($urandom), en, swp, scl, px, py};
    endtask

    task automatic random_sat(input logic [8:0] ny);
        for (int i = 0; i < NSPR; i++) begin
            logic [8:0] py;
            if ($urandom_range(0, 3) == 0) py = 9'($urandom);
            else py = ny - 9'($urandom_range(0, 19));
            set_w0(i, 1'($urandom), py, 9'($urandom), 4'($urandom), 1'($urandom));
            mem[SAT + 16'(2 * i + 1)] = $urandom;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        logic [8:0] y;

        for (int a = 0; a < 65536; a++) mem[a] = $urandom;
        rst      = 1'b0;
        CounterX = 10'd0;
        CounterY = 9'd0;
        repeat (3) @(negedge clk);
        chk("reset_addr", 66'(addr), 66'd0);
        chk("reset_ent", {posX, sclX, swpX, bcol1, bcol2, bcol3, bcol4, colors}, 66'd0);
        chk("reset_ctl", 66'({clr, shift, busy, overflow}), 66'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single sprite at SAT index 3
        clear_sat();
        set_w0(3, 1'b1, 9'd100, 9'd50, 4'd2, 1'b1);
        mem[SAT + 16'd7] = {12'h010, 20'($urandom)};
        mem[16'h0104]    = 32'hA5A5_5A5A;
        run_line(9'd103, -1);
        chk("single_posx", 66'(got_q[line_s0][65:57]), 66'd50);
        chk("single_colors", 66'(got_q[line_s0][31:0]), 66'hA5A5_5A5A);
        found = 1'b0;
        for (int k = line_a0; k < addr_q.size(); k++) if (addr_q[k] == 16'h0104) found = 1'b1;
        chk("single_addr_0104", 66'(found), 66'd1);

        // Overflow: 10 hits on line 200, only SAT 0..7 pushed
        clear_sat();
        for (int k = 0; k < 10; k++) set_w0(k, 1'b1, 9'(200 - k), 9'(k), 4'd0, 1'b0);
        run_line(9'd199, -1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("ovf_order%0d", k), 66'(got_q[line_s0 + k][65:57]), 66'(k));
        chk("ovf_set", 66'(overflow), 66'd1);
        clear_sat();
        run_line(9'd300, -1);
        chk("ovf_held", 66'(overflow), 66'd1);

        // Last line of frame -> line 0, sprite at posY 0 hits with row 0
        clear_sat();
        set_w0(0, 1'b1, 9'd0, 9'd77, 4'd1, 1'b0);
        run_line(9'(LY), -1);
        chk("ovf_cleared", 66'(overflow), 66'd0);
        chk("line0_hits", 66'(got_q.size() - line_s0), 66'd1);

        // Row boundaries: row 15 hits, row 16 misses, disabled entry misses
        clear_sat();
        set_w0(0, 1'b1, 9'd20, 9'd11, 4'd0, 1'b0);
        set_w0(1, 1'b1, 9'd19, 9'd12, 4'd0, 1'b0);
        set_w0(2, 1'b0, 9'd30, 9'd13, 4'd0, 1'b0);
        run_line(9'd34, -1);
        chk("row15_posx", 66'(got_q[line_s0][65:57]), 66'd11);

        // Blank line: no scan at all
        n = n_clr;
        run_line(9'd479, -1);
        repeat (4) begin
            @(negedge clk);
            chk("blank_idle", 66'(busy), 66'd0);
        end
        chk("blank_noclr", 66'(n_clr - n), 66'd0);

        // Second START_X pulse while busy is ignored
        random_sat(9'd61);
        run_line(9'd60, 5);

        // Reset during W1 aborts the scan
        clear_sat();
        set_w0(0, 1'b1, 9'd45, 9'd99, 4'd3, 1'b1);
        CounterY = 9'd50;
        CounterX = 10'(STX);
        @(negedge clk);
        CounterX = 10'd0;
        n = 0;
        while (addr !== SAT + 16'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_w1", 66'(addr === SAT + 16'd1), 66'd1);
        rst     = 1'b0;
        line_s0 = got_q.size();
        @(negedge clk);
        chk("midrst_addr", 66'(addr), 66'd0);
        chk("midrst_ent", {posX, sclX, swpX, bcol1, bcol2, bcol3, bcol4, colors}, 66'd0);
        chk("midrst_ctl", 66'({clr, shift, busy, overflow}), 66'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_noshift", 66'(got_q.size() - line_s0), 66'd0);
        exp_ovf = 1'b0;
        run_line(9'd50, -1);

        // Randomized lines against the reference model
        for (int t = 0; t < 20; t++) begin
            y = 9'($urandom_range(0, 478));
            random_sat(y + 9'd1);
            run_line(y, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
